// File: rtl/fib_driver.sv
// Fibonacci engine driver: writes the two seeds over the shared register bus, starts the engine,
// waits for it to finish, then reads the pair back. FIB_DRIVER_TIMEOUT_EN adds a WAIT-phase watchdog.
module fib_driver #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_seed_a,
  input  logic [7:0] cmd_seed_b,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i,
  output logic       bus_address,
  output logic       bus_we,
  output logic       bus_oe,
  output logic       bus_start,
  input  logic       bus_busy,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_a,
  output logic [7:0] rsp_b,
  output logic       rsp_timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, START, WAIT, RD_A, RD_B, RESP
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       timeout;
  } rsp_t;

  state_t     state, state_nxt;
  logic [7:0] seed_a, seed_b;
  rsp_t       rsp_q;
  logic       cmd_fire;
  logic       wait_expired;

  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef FIB_DRIVER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  // Cleared while in START so the first WAIT cycle sees zero.
  always_ff @(posedge clk) begin
    if (reset)                wait_cnt <= '0;
    else if (state == START)  wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end

  assign wait_expired = (state == WAIT) && bus_busy && (wait_cnt == WAIT_LAST);
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    bus_data_o  = '0;
    bus_data_oe = 1'b0;
    bus_address = 1'b0;
    bus_we      = 1'b0;
    bus_oe      = 1'b0;
    bus_start   = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        // An engine still running after a watchdog abort blocks new commands.
        cmd_ready = !bus_busy;
        if (cmd_valid && !bus_busy) state_nxt = WR_A;
      end
      WR_A: begin
        bus_we      = 1'b1;
        bus_data_oe = 1'b1;
        bus_data_o  = seed_a;
        state_nxt   = WR_B;
      end
      WR_B: begin
        bus_address = 1'b1;
        bus_we      = 1'b1;
        bus_data_oe = 1'b1;
        bus_data_o  = seed_b;
        state_nxt   = START;
      end
      START: begin
        bus_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!bus_busy)         state_nxt = RD_A;
        else if (wait_expired) state_nxt = RESP;
      end
      RD_A: begin
        bus_oe    = 1'b1;
        state_nxt = RD_B;
      end
      RD_B: begin
        bus_address = 1'b1;
        bus_oe      = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_a <= '0;
      seed_b <= '0;
      rsp_q  <= '0;
    end else begin
      if (cmd_fire) begin
        seed_a <= cmd_seed_a;
        seed_b <= cmd_seed_b;
        rsp_q  <= '0;
      end
      if (state == RD_A) rsp_q.a <= bus_data_i;
      if (state == RD_B) rsp_q.b <= bus_data_i;
      if (wait_expired)  rsp_q <= '{a: 8'h00, b: 8'h00, timeout: 1'b1};
    end
  end

  assign rsp_a       = rsp_q.a;
  assign rsp_b       = rsp_q.b;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_fib_driver.sv
// Bench for fib_driver: behavioural Fibonacci engine on the shared bus, table of seed vectors with a
// response scoreboard, plus hand sequences for busy hold-off, reset mid-WAIT and the watchdog.
module tb_fib_driver;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [7:0] cmd_seed_a, cmd_seed_b, bus_data_o, bus_data_i, rsp_a, rsp_b;
  logic       bus_data_oe, bus_address, bus_we, bus_oe, bus_start, bus_busy;

  always #5 clk = ~clk;

  fib_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_seed_a(cmd_seed_a), .cmd_seed_b(cmd_seed_b),
    .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i),
    .bus_address(bus_address), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_start(bus_start), .bus_busy(bus_busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_timeout(rsp_timeout)
  );

  // Engine: one step per cycle, a <= a+b, b <= larger of the pair, stops on 8-bit overflow.
  logic [7:0] eng_a = 8'h00, eng_b = 8'h00;
  logic       eng_busy = 1'b0, eng_kill = 1'b0, eng_force = 1'b0;
  logic [8:0] eng_sum;
  assign eng_sum     = {1'b0, eng_a} + {1'b0, eng_b};
  assign bus_busy    = eng_busy | eng_force;
  assign bus_data_i  = bus_data_oe ? bus_data_o :
                       (bus_oe ? (bus_address ? eng_b : eng_a) : 8'h00);

  always @(posedge clk) begin
    if (eng_kill) eng_busy <= 1'b0;
    else if (eng_busy) begin
      if (eng_sum[8]) eng_busy <= 1'b0;
      else begin
        eng_a <= eng_sum[7:0];
        eng_b <= (eng_a > eng_b) ? eng_a : eng_b;
      end
    end else if (bus_start) eng_busy <= 1'b1;
    if (bus_we && !bus_busy) begin
      if (bus_address) eng_b <= bus_data_i;
      else             eng_a <= bus_data_i;
    end
  end

  typedef struct { logic [7:0] a; logic [7:0] b; logic to; } rsp_t;
  typedef struct {
    logic [7:0] sa; logic [7:0] sb; int hold;
    logic [7:0] ea; logic [7:0] eb; logic eto; int lat;
  } vec_t;

  rsp_t exp_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    check({tag, "_cmd_ready_wait"}, int'(cmd_ready), 1);
  endtask

  task automatic run_cmd(input logic [7:0] sa, input logic [7:0] sb, input int hold,
                         input logic [7:0] ea, input logic [7:0] eb, input logic eto,
                         input int lat_exp, input string tag);
    rsp_t exp;
    int   lat;
    wait_ready(tag);
    cmd_valid  = 1'b1;
    cmd_seed_a = sa;
    cmd_seed_b = sb;
    rsp_ready  = (hold == 0);
    exp_q.push_back('{a: ea, b: eb, to: eto});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    exp = exp_q.pop_front();
    if (!rsp_valid) begin
      check({tag, "_rsp_valid_timeout"}, 0, 1);
      return;
    end
    check({tag, "_rsp_a"}, int'(rsp_a), int'(exp.a));
    check({tag, "_rsp_b"}, int'(rsp_b), int'(exp.b));
    check({tag, "_rsp_timeout"}, int'(rsp_timeout), int'(exp.to));
    if (lat_exp > 0) check({tag, "_latency"}, lat, lat_exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stable"}, int'({rsp_valid, rsp_a, rsp_b, rsp_timeout}),
            int'({1'b1, exp.a, exp.b, exp.to}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after_handshake"}, int'(rsp_valid), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_outs"},
          int'({bus_we, bus_oe, bus_start, bus_data_oe, bus_address, bus_data_o}), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_regs"}, int'({rsp_a, rsp_b, rsp_timeout}), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), int'(!(eng_busy | eng_force)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_fib_driver stuck");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_seed_a = '0; cmd_seed_b = '0; rsp_ready = 1'b0;

    vecs[0] = '{sa: 1,   sb: 1,   hold: 0, ea: 233, eb: 144, eto: 0, lat: 18};
    vecs[1] = '{sa: 200, sb: 100, hold: 0, ea: 200, eb: 100, eto: 0, lat: 7};
    vecs[2] = '{sa: 1,   sb: 1,   hold: 5, ea: 233, eb: 144, eto: 0, lat: 18};
    vecs[3] = '{sa: 5,   sb: 3,   hold: 0, ea: 233, eb: 144, eto: 0, lat: 0};
    vecs[4] = '{sa: 100, sb: 200, hold: 0, ea: 100, eb: 200, eto: 0, lat: 7};
    vecs[5] = '{sa: 255, sb: 0,   hold: 2, ea: 255, eb: 255, eto: 0, lat: 8};
    vecs[6] = '{sa: 0,   sb: 1,   hold: 0, ea: 233, eb: 144, eto: 0, lat: 0};
    vecs[7] = '{sa: 144, sb: 89,  hold: 1, ea: 233, eb: 144, eto: 0, lat: 8};

    // Bus protocol monitor, sampled every cycle away from the active edge.
    fork
      forever begin
        @(negedge clk);
        if (!reset && bus_data_oe && (bus_oe || bus_busy)) begin
          failures++;
          $display("FAIL bus_conflict: data_oe=%0b oe=%0b busy=%0b, required data_oe=0",
                   bus_data_oe, bus_oe, bus_busy);
        end
        if (!reset && bus_busy && (bus_we || bus_oe || bus_start || bus_data_oe)) begin
          failures++;
          $display("FAIL bus_active_while_busy: we=%0b oe=%0b start=%0b data_oe=%0b, required 0",
                   bus_we, bus_oe, bus_start, bus_data_oe);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    foreach (vecs[i])
      run_cmd(vecs[i].sa, vecs[i].sb, vecs[i].hold, vecs[i].ea, vecs[i].eb,
              vecs[i].eto, vecs[i].lat, $sformatf("vec%0d", i));

    // Engine busy while idle: a pending command must not be accepted.
    wait_ready("busy");
    eng_force = 1'b1; cmd_valid = 1'b1; cmd_seed_a = 8'd9; cmd_seed_b = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_hold_cmd_ready", int'(cmd_ready), 0);
      check("busy_hold_we", int'(bus_we), 0);
    end
    eng_force = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_release_cmd_ready", int'(cmd_ready), 1);

    // Reset in the middle of WAIT, then a fresh command.
    begin
      int n = 0;
      wait_ready("rst");
      cmd_valid = 1'b1; cmd_seed_a = 8'd1; cmd_seed_b = 8'd1; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      while (!bus_busy && n < 20) begin @(negedge clk); n++; end
      check("rst_engine_busy", int'(bus_busy), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("rst_mid_wait");
      check("rst_mid_wait_blocked", int'(cmd_ready), 0);
      run_cmd(8'd3, 8'd5, 0, 8'd233, 8'd144, 1'b0, 0, "after_rst");
    end

`ifdef FIB_DRIVER_TIMEOUT_EN
    // Seeds (0,0) never overflow, so the engine stays busy until the watchdog fires.
    run_cmd(8'd0, 8'd0, 0, 8'd0, 8'd0, 1'b1, 3 + TO, "timeout");
    cmd_valid = 1'b1; cmd_seed_a = 8'd7; cmd_seed_b = 8'd7;
    for (int i = 0; i < 4; i++) begin
      check("timeout_cmd_ready_held", int'(cmd_ready), 0);
      check("timeout_no_write", int'(bus_we), 0);
      @(negedge clk);
    end
    eng_kill = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    eng_kill = 1'b0;
    check("timeout_engine_done_ready", int'(cmd_ready), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
